// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

   localparam int DATA_W     = 8;
   localparam int FRAME_BITS = 10;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      START,
      DATA,
      STOP
   } uart_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter; bit_end marks the last clock of each UART bit.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic bit_end
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear || cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_end = !clear && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from syn_fifo and sends them as back-to-back 8N1 frames.
module fifo_uart_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] fifo_data,
   input  logic              fifo_empty,
   output logic              fifo_read_en,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);

   import fifo_uart_pkg::*;

   localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

   uart_state_t       state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic              tx_q, tx_d;
   logic              bit_end;
   logic              timer_clear;

   assign timer_clear = (state_q == IDLE) || (state_q == FETCH);

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (timer_clear),
      .bit_end(bit_end)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) state_d = FETCH;
         end
         FETCH: begin
            shift_d   = fifo_data;
            bit_idx_d = '0;
            state_d   = START;
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               bit_idx_d = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == LAST_BIT) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (bit_end) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Line level follows the next state so tx comes straight off a flop.
      tx_d = 1'b1;
      if (state_d == START) begin
         tx_d = 1'b0;
      end else if (state_d == DATA) begin
         tx_d = shift_d[0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
      end
   end

   assign fifo_read_en = !reset && (state_q == IDLE) && !fifo_empty;
   assign tx           = tx_q;
   assign busy         = (state_q != IDLE);
   assign tx_done      = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: FIFO model upstream, frame decoder monitor downstream.
module tb_fifo_uart_tx;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] fifo_data;
   logic       fifo_empty;
   logic       fifo_read_en;
   logic       tx;
   logic       busy;
   logic       tx_done;

   always #5 clk = ~clk;

   fifo_uart_tx #(
      .DATA_W      (8),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .fifo_data   (fifo_data),
      .fifo_empty  (fifo_empty),
      .fifo_read_en(fifo_read_en),
      .tx          (tx),
      .busy        (busy),
      .tx_done     (tx_done)
   );

   // Upstream FIFO: depth 8, data_out valid the cycle after the read edge
   logic [7:0] fmem[$];
   int         fcount = 0;
   int         pops = 0;
   int         writes = 0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;

   assign fifo_empty = (fcount == 0);

   always @(posedge clk) begin
      int rd;
      rd = (fifo_read_en && fcount > 0) ? 1 : 0;
      if (rd == 1) begin
         fifo_data <= fmem.pop_front();
         pops <= pops + 1;
      end
      if (wr_en) fmem.push_back(wr_data);
      fcount <= fcount + (wr_en ? 1 : 0) - rd;
   end

   // Scoreboard
   logic [7:0] exp_q[$];
   int         starts[$];
   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   int         stray = 0;
   bit         in_frame = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Monitor: every frame is compared cycle by cycle with the ideal 8N1 waveform
   initial begin
      int         off;
      int         bad;
      logic [7:0] cur;
      logic       prev_tx;
      logic       eb;
      int         k;
      off = 0;
      bad = 0;
      cur = 8'h00;
      prev_tx = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            in_frame = 1'b0;
         end else if (!in_frame && prev_tx === 1'b1 && tx === 1'b0) begin
            in_frame = 1'b1;
            off = 0;
            bad = 0;
            starts.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("unexpected_frame", 1, 0);
               cur = 8'h00;
            end else begin
               cur = exp_q[0];
            end
         end else if (!in_frame && tx_done !== 1'b0) begin
            stray++;
         end
         if (in_frame) begin
            k = off / CPB;
            if (k == 0) eb = 1'b0;
            else if (k == 9) eb = 1'b1;
            else eb = cur[k-1];
            if (tx !== eb) bad++;
            if (tx_done !== (off == FRAME - 1)) bad++;
            if (busy !== 1'b1) bad++;
            if (off == FRAME - 1) begin
               check($sformatf("frame_%02h_bad_cycles", cur), bad, 0);
               in_frame = 1'b0;
               if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            off++;
         end
         prev_tx = tx;
      end
   end

   task automatic write_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (fcount >= 8 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) check("write_full_timeout", 1, 0);
      wr_en = 1'b1;
      wr_data = b;
      exp_q.push_back(b);
      writes++;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (!(fcount == 0 && !busy && exp_q.size() == 0 && !in_frame)
             && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain_in_time"}, (n < 5000), 1);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int e;
      int n0;
      int t0;
      int n;
      logic [7:0] fill[8];
      fill = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0d, 8'h8d, 8'h65, 8'h12};

      // Reset values
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rst_tx", tx, 1);
         check("rst_busy", busy, 0);
         check("rst_read_en", fifo_read_en, 0);
         check("rst_tx_done", tx_done, 0);
      end
      #1 reset = 1'b0;

      // Single byte
      write_byte(8'h24);
      drain("single");
      check("single_pops", pops, 1);
      check("single_empty", fifo_empty, 1);

      // Back-to-back frames
      starts.delete();
      write_byte(8'h81);
      write_byte(8'h09);
      write_byte(8'h63);
      drain("b2b");
      check("b2b_frames", starts.size(), 3);
      for (int i = 1; i < starts.size(); i++)
         check("b2b_spacing", starts[i] - starts[i-1], 10 * CPB + 2);
      check("b2b_pops", pops, 4);

      // Empty FIFO stays idle
      e = 0;
      repeat (100) begin
         @(negedge clk);
         if (fifo_read_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) e++;
      end
      check("empty_idle_bad_cycles", e, 0);

      // Reset during data bit 3
      n0 = starts.size();
      write_byte(8'h8d);
      write_byte(8'h65);
      n = 0;
      while (starts.size() <= n0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("midrst_frame_seen", (starts.size() > n0), 1);
      if (starts.size() > n0) begin
         t0 = starts[n0];
         n = 0;
         do begin
            @(negedge clk);
            #1;
            n++;
         end while (cyc < t0 + 17 && n < 100);
      end
      reset = 1'b1;
      void'(exp_q.pop_front());
      #1;
      check("midrst_tx", tx, 1);
      check("midrst_busy", busy, 0);
      check("midrst_read_en", fifo_read_en, 0);
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      #1 check("release_read_en", fifo_read_en, 1);
      drain("midrst");
      check("midrst_pops", pops, writes);

      // Fill to full while held in reset, then drain
      @(negedge clk);
      #1 reset = 1'b1;
      foreach (fill[i]) write_byte(fill[i]);
      check("fill_full", (fcount == 8), 1);
      check("fill_read_en", fifo_read_en, 0);
      @(negedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("full_after_pop", fcount, 7);
      drain("fill");
      check("fill_pops", pops, writes);
      repeat (20) @(negedge clk);
      check("fill_no_extra_pop", pops, writes);

      // Randomized bursts
      repeat (25) begin
         n = $urandom_range(1, 5);
         repeat (n) write_byte(8'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 60)) @(negedge clk);
      end
      drain("random");
      check("random_pops", pops, writes);
      check("random_exp_left", exp_q.size(), 0);
      check("stray_tx_done", stray, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors,
               miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for `syn_fifo`. It pops one byte at a time from the FIFO read port and serialises it on a UART 8N1 line, LSB first. Frames go out back-to-back until the FIFO reports empty. It connects directly to `syn_fifo`: `data_out`/`empty` come in, and `read_en` goes back out.

## Interface
Parameters:
- `DATA_W`, default 8: byte width. Must match `syn_fifo`; only 8 is supported.
- `CLKS_PER_BIT`, default 4: clock cycles per UART bit. Legal range is ≥2.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fifo_data`  in  8  connects to `syn_fifo.data_out`; valid the cycle after a read edge.
- `fifo_empty`  in  1  connects to `syn_fifo.empty`.
- `fifo_read_en`  out  1  connects to `syn_fifo.read_en`; one-cycle pop request.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high while a byte is being fetched or transmitted.
- `tx_done`  out  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- FSM states: IDLE, FETCH, START, DATA, STOP.
- **IDLE**
  - `fifo_read_en` = `!fifo_empty`. This is combinational and asserted in IDLE only.
  - If `!fifo_empty` at the edge, go to FETCH. Otherwise stay.
- **FETCH** (exactly 1 cycle)
  - `fifo_data` now holds the popped byte.
  - Capture it into the shift register at the edge, clear the bit counter, go to START.
- **START**
  - `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- **DATA**
  - `tx` = `shift[0]` for `CLKS_PER_BIT` cycles per bit.
  - Shift right after each bit.
  - After bit index 7, go to STOP.
- **STOP**
  - `tx`=1 for `CLKS_PER_BIT` cycles.
  - `tx_done`=1 in the final cycle only.
  - Then go to IDLE.
- `busy` = 1 in FETCH, START, DATA and STOP.
- `tx` = 1 in IDLE and FETCH.
- `tx` is registered; no combinational glitches on the line.
- Bit-period counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1, and the wrap marks the bit boundary.
- Bit index counter is 3 bits and must not wrap past 7.
- `fifo_empty` is ignored outside IDLE. Exactly one pop is issued per frame.

## Timing
- Reset values: `tx`=1, `busy`=0, `tx_done`=0, `fifo_read_en`=0. State is IDLE and all counters are 0.
- Pop to first start-bit cycle: 2 edges (IDLE→FETCH→START).
- Frame length: 10·`CLKS_PER_BIT` cycles.
- Back-to-back frames: start-bit to start-bit spacing is 10·`CLKS_PER_BIT`+2 cycles. The two high cycles come from IDLE + FETCH.
- Reset asserted mid-frame:
  - `tx` goes to 1 and `busy` to 0 immediately (asynchronous).
  - The in-flight byte is discarded.
  - No extra pop is issued.
- Reset deassertion with FIFO non-empty: `fifo_read_en` rises in the first IDLE cycle.
- `fifo_read_en` is forced to 0 while `reset`=1.
- FIFO empty: the block stays in IDLE indefinitely. No pop is issued, so there is no underflow.

## Structure
- Package `fifo_uart_pkg` holds:
  - the `uart_state_t` enum (IDLE, FETCH, START, DATA, STOP);
  - `DATA_W` = 8;
  - `FRAME_BITS` = 10.
- One sub-module, `uart_bit_timer`:
  - parameter `CLKS_PER_BIT`;
  - inputs `clk`, `reset`, `clear`;
  - output `bit_end`, a pulse in the last cycle of each bit period.
- The FSM, shift register and bit counter live in the top module.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 with `syn_fifo` instantiated upstream.

- **Reset values:** hold `reset`=1 for 2 cycles → `tx`=1, `busy`=0, `fifo_read_en`=0 throughout.
- **Single byte 0x24:**
  - Write 0x24 → exactly one `fifo_read_en` pulse.
  - `tx` sequence, 4 cycles each: 0 | 0,0,1,0,0,1,0,0 | 1.
  - `tx_done` pulses once, at cycle 40 of the frame.
  - `fifo_empty`=1 afterwards.
- **Back-to-back 0x81, 0x09, 0x63:**
  - Write all three before drain → three pops.
  - Start-bit falling edges are 42 cycles apart.
  - Decoded bytes are 81, 09, 63 in order.
- **Empty FIFO:** run 100 cycles with nothing written → `fifo_read_en` never asserts, `tx`=1, `busy`=0.
- **Reset mid-frame:**
  - Assert `reset` during data bit 3 of 0x8d → `tx`=1 asynchronously.
  - After release, the next queued byte 0x65 is sent intact.
  - Pop count equals bytes written.
- **Fill FIFO to full (8 bytes 24, 81, 09, 63, 0d, 8d, 65, 12) and drain:**
  - All 8 bytes are received in order.
  - `full` deasserts after the first pop.
  - No extra pop occurs at empty.
